// File: rtl/sprite_draw_sched_pkg.sv
// Shared types and constants for the sprite draw scheduler.
//   state_t : scheduler FSM states
//   rect_t  : rectangle as handed to the scan-driven framebuffer writer
//             (x_end / y_end are exclusive)
//   PAL_*   : palette indices; BG_COLOR is the erase colour (BLACK)
package sprite_draw_sched_pkg;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 4;

    localparam logic [COLOR_W-1:0] PAL_RED    = 4'd0;
    localparam logic [COLOR_W-1:0] PAL_ORANGE = 4'd1;
    localparam logic [COLOR_W-1:0] PAL_YELLOW = 4'd2;
    localparam logic [COLOR_W-1:0] PAL_GREEN  = 4'd3;
    localparam logic [COLOR_W-1:0] PAL_CYAN   = 4'd4;
    localparam logic [COLOR_W-1:0] PAL_BLUE   = 4'd5;
    localparam logic [COLOR_W-1:0] PAL_PINK   = 4'd6;
    localparam logic [COLOR_W-1:0] PAL_BLACK  = 4'd7;
    localparam logic [COLOR_W-1:0] PAL_WHITE  = 4'd8;
    localparam logic [COLOR_W-1:0] PAL_GRAY   = 4'd9;
    localparam logic [COLOR_W-1:0] BG_COLOR   = PAL_BLACK;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        ERASE = 3'd2,
        DRAW  = 3'd3,
        ACK   = 3'd4
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x_start;
        logic [COORD_W-1:0] x_end;
        logic [COORD_W-1:0] y_start;
        logic [COORD_W-1:0] y_end;
    } rect_t;

    function automatic rect_t empty_rect();
        return '0;
    endfunction

endpackage

// File: rtl/sprite_draw_sched_if.sv
// Requester-side bus of the sprite draw scheduler.
//   req          : per-requester level request, held until ack
//   req_x_start.. : packed rectangles, requester i at [i*COORD_W +: COORD_W]
//   req_color    : packed palette indices, requester i at [i*COLOR_W +: COLOR_W]
//   ack          : one-cycle done pulse to the granted requester
// Modports: master = game logic (requesters), slave = scheduler.
interface sprite_draw_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int COORD_W = 10,
    parameter int COLOR_W = 4
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*COORD_W-1:0] req_x_start;
    logic [NUM_REQ*COORD_W-1:0] req_x_end;
    logic [NUM_REQ*COORD_W-1:0] req_y_start;
    logic [NUM_REQ*COORD_W-1:0] req_y_end;
    logic [NUM_REQ*COLOR_W-1:0] req_color;
    logic [NUM_REQ-1:0]         ack;

    modport master (
        output req, req_x_start, req_x_end, req_y_start, req_y_end, req_color,
        input  ack
    );

    modport slave (
        input  req, req_x_start, req_x_end, req_y_start, req_y_end, req_color,
        output ack
    );
endinterface

// File: rtl/sprite_draw_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : highest-priority index this round
//   grant     : one-hot grant (first set bit at or after ptr, wrapping)
//   grant_idx : index of the granted bit
//   valid     : some request is set
module sprite_draw_sched_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               valid
);
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!valid && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                valid       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sprite_draw_sched.sv
// Sprite draw scheduler: shares the framebuffer writer's single rectangle
// port among NUM_REQ requesters. Round-robin grant; the granted rectangle is
// held on the port for exactly one frame, start-of-frame to start-of-frame.
//
// Optional build macro SPRITE_ERASE_EN: keeps the last drawn rectangle per
// requester and paints it in BG_COLOR for one frame before the new draw.
//
// Ports:
//   vga_clk, sys_rst_n : pixel clock, async active-low reset
//   pix_x, pix_y       : current scan position
//   req_bus            : requester bus (slave modport)
//   char_*             : rectangle + colour to the writer
//   busy               : high whenever the FSM is not IDLE
//
// state | meaning
// IDLE  | waiting for a request; arbitrate and snapshot the winner
// ARM   | granted, empty rect on port, waiting for start of frame
// ERASE | old rect of the grant in BG_COLOR for one frame
// DRAW  | snapshot rect and colour for one frame
// ACK   | one-cycle ack to the grant, advance rr pointer
module sprite_draw_sched
    import sprite_draw_sched_pkg::*;
#(
    parameter int                 NUM_REQ  = 4,
    parameter int                 COORD_W  = sprite_draw_sched_pkg::COORD_W,
    parameter int                 COLOR_W  = sprite_draw_sched_pkg::COLOR_W,
    parameter logic [COLOR_W-1:0] BG_COLOR = sprite_draw_sched_pkg::BG_COLOR
) (
    input  logic               vga_clk,
    input  logic               sys_rst_n,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    sprite_draw_sched_if.slave req_bus,
    output logic [COORD_W-1:0] char_x_start,
    output logic [COORD_W-1:0] char_x_end,
    output logic [COORD_W-1:0] char_y_start,
    output logic [COORD_W-1:0] char_y_end,
    output logic [COLOR_W-1:0] char_color,
    output logic               busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   grant_idx_q;
    rect_t              snap_q;
    logic [COLOR_W-1:0] snap_color_q;
    logic               pix_zero, pix_zero_q, sof_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    rect_t              sel_rect;
    logic [COLOR_W-1:0] sel_color;

    rect_t              char_rect;
    logic [COLOR_W-1:0] char_color_c;
    logic [NUM_REQ-1:0] ack_c;
    logic               erase_hit;
    rect_t              erase_rect;

    sprite_draw_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_bus.req),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    // Only the winner's slice is muxed out; other requesters may change freely.
    always_comb begin
        sel_rect  = empty_rect();
        sel_color = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_rect.x_start = req_bus.req_x_start[i*COORD_W +: COORD_W];
                sel_rect.x_end   = req_bus.req_x_end[i*COORD_W +: COORD_W];
                sel_rect.y_start = req_bus.req_y_start[i*COORD_W +: COORD_W];
                sel_rect.y_end   = req_bus.req_y_end[i*COORD_W +: COORD_W];
                sel_color        = req_bus.req_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    assign pix_zero = (pix_x == '0) && (pix_y == '0);

`ifdef SPRITE_ERASE_EN
    rect_t              old_rect_q [NUM_REQ];
    logic [NUM_REQ-1:0] old_valid_q;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            old_valid_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                old_rect_q[i] <= empty_rect();
            end
        end else if (state_q == ACK) begin
            old_rect_q[grant_idx_q]  <= snap_q;
            old_valid_q[grant_idx_q] <= 1'b1;
        end
    end

    assign erase_hit  = old_valid_q[grant_idx_q];
    assign erase_rect = old_rect_q[grant_idx_q];
`else
    assign erase_hit  = 1'b0;
    assign erase_rect = empty_rect();
`endif

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_idx_q  <= '0;
            snap_q       <= empty_rect();
            snap_color_q <= BG_COLOR;
            pix_zero_q   <= 1'b0;
            sof_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_zero_q <= pix_zero;
            sof_q      <= pix_zero & ~pix_zero_q;
            if (state_q == IDLE && arb_valid) begin
                grant_idx_q  <= arb_idx;
                snap_q       <= sel_rect;
                snap_color_q <= sel_color;
            end
            if (state_q == ACK) begin
                rr_ptr_q <= (grant_idx_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx_q + 1'b1;
            end
        end
    end

    // sof_q is registered, so a sof coinciding with the IDLE grant has
    // already gone by the time ARM looks at it.
    always_comb begin
        state_d      = state_q;
        char_rect    = empty_rect();
        char_color_c = BG_COLOR;
        ack_c        = '0;
        case (state_q)
            IDLE: begin
                if (arb_valid) state_d = ARM;
            end
            ARM: begin
                if (sof_q) state_d = erase_hit ? ERASE : DRAW;
            end
            ERASE: begin
                char_rect = erase_rect;
                if (sof_q) state_d = DRAW;
            end
            DRAW: begin
                char_rect    = snap_q;
                char_color_c = snap_color_q;
                if (sof_q) state_d = ACK;
            end
            ACK: begin
                ack_c[grant_idx_q] = 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign char_x_start = char_rect.x_start;
    assign char_x_end   = char_rect.x_end;
    assign char_y_start = char_rect.y_start;
    assign char_y_end   = char_rect.y_end;
    assign char_color   = char_color_c;
    assign req_bus.ack  = ack_c;
    assign busy         = (state_q != IDLE);

endmodule
